// File: rtl/sub_serial_pkg.sv
// Shared definitions for the serial arithmetic units: control FSM encoding
// and default datapath sizing.
package sub_serial_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

  // Encoding is shared with the serial adder's control FSM; code 3 is unused.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SUB  = ST_SUB,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_fs.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
module serial_fs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: latches a/b on en, produces a - b LSB first over
// WIDTH cycles using a single borrow flop, then holds the result in DONE.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             start;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] count;
  logic             brw;
  logic             d_bit;
  logic             brw_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          start     = 1'b1;
          state_nxt = SUB;
        end
      end
      SUB: begin
        step = 1'b1;
        if (count == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  serial_fs u_fs (
    .x   (a_reg[0]),
    .y   (b_reg[0]),
    .bin (brw),
    .d   (d_bit),
    .bout(brw_nxt)
  );

  // Operand shift registers: present the next bit pair at position 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (start) begin
      a_reg <= a;
      b_reg <= b;
    end else if (step) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
    end
  end

  // Running borrow and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brw   <= 1'b0;
      count <= '0;
    end else if (start) begin
      brw   <= 1'b0;
      count <= '0;
    end else if (step) begin
      brw   <= brw_nxt;
      count <= count + CNT_W'(1);
    end
  end

  // Result fills from the MSB so the first (LSB) bit lands at bit 0 last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       out <= '0;
    else if (start) out <= '0;
    else if (step)  out <= {d_bit, out[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       borrow <= 1'b0;
    else if (start) borrow <= 1'b0;
    else if (last)  borrow <= brw_nxt;
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Directed and randomized check of sub_serial against an arithmetic model.
module tb_sub_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         borrow;
  logic         done;

  int vectors;
  int miscompares;

  sub_serial #(.WIDTH(W), .CNT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .a     (a),
    .b     (b),
    .out   (out),
    .borrow(borrow),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full operation; hold keeps en high and scrambles a/b during SUB.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input bit hold, input bit do_ack);
    logic [W-1:0] eo;
    logic         eb;
    int           n;
    eo = ta - tb_v;
    eb = (ta < tb_v);
    a  = ta;
    b  = tb_v;
    en = 1'b1;
    tick();
    if (!hold) en = 1'b0;
    chk("borrow_cleared", borrow, 0);
    n = 0;
    while (done !== 1'b1 && n < W + 4) begin
      if (hold) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      n++;
    end
    chk("latency", n, W);
    chk("out", out, eo);
    chk("borrow", borrow, eb);
    if (do_ack) begin
      if (!hold) begin
        tick();
        chk("done_hold", done, 1);
        chk("out_hold", out, eo);
        en = 1'b1;
      end
      tick();
      chk("ack_done", done, 0);
      en = 1'b0;
      tick();
      chk("idle_done", done, 0);
      chk("idle_out", out, eo);
      chk("idle_borrow", borrow, eb);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    tick();
    tick();
    chk("rst_out", out, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    tick();
    chk("idle_no_start", done, 0);

    run_op(8'd200, 8'd55, 1'b0, 1'b1);
    run_op(8'd5,   8'd10, 1'b0, 1'b1);
    run_op(8'd0,   8'd1,  1'b0, 1'b1);
    run_op(8'd255, 8'd255, 1'b0, 1'b1);
    run_op(8'd0,   8'd0,  1'b0, 1'b1);
    run_op(8'd77,  8'd0,  1'b0, 1'b1);
    run_op(8'd200, 8'd55, 1'b1, 1'b1);

    // Abort in the 4th SUB cycle; a leftover partial result must vanish.
    a  = 8'd77;
    b  = 8'd20;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("abort_out", out, 0);
    chk("abort_borrow", borrow, 0);
    chk("abort_done", done, 0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("abort_idle", done, 0);
    run_op(8'd9, 8'd3, 1'b0, 1'b1);

    run_op(8'd100, 8'd1, 1'b0, 1'b1);
    run_op(8'd1, 8'd100, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
